// File: rtl/branch_predictor_pkg.sv
// Shared widths, 2-bit counter encodings and the sequential-fetch increment for the branch predictor.
// No logic of its own; constants and one helper function only.
// Not applicable (no handshake).
package branch_predictor_pkg;

    // Default table geometry: index width (128 entries) and partial tag width.
    localparam int BpIdxBus = 7;
    localparam int BpTagBus = 8;

    // Two-bit saturating counter encodings.
    localparam logic [1:0] CNT_SNT = 2'b00;  // strongly not-taken
    localparam logic [1:0] CNT_WNT = 2'b01;  // weakly not-taken
    localparam logic [1:0] CNT_WT  = 2'b10;  // weakly taken
    localparam logic [1:0] CNT_ST  = 2'b11;  // strongly taken

    // Fall-through distance between sequential instructions.
    localparam logic [31:0] PC_INCR = 32'd4;

    // Sequential next PC, wrapping modulo 2^32.
    function automatic logic [31:0] pc_next_seq(input logic [31:0] pc);
        return pc + PC_INCR;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Next-state function of a 2-bit saturating direction counter.
// Purely combinational, zero latency.
// No handshake; caller decides when the result is written back.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_nxt
);

    // Step toward the actual direction, holding at the end points.
    always_comb begin
        cnt_nxt = cnt;
        if (taken) begin
            if (cnt != CNT_ST) begin
                cnt_nxt = cnt + 2'b01;
            end
        end else begin
            if (cnt != CNT_SNT) begin
                cnt_nxt = cnt - 2'b01;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB + 2-bit counters, trained from EX; optional gshare via `BP_GSHARE_EN.
// Lookup is combinational (zero latency); training writes land on the next posedge and are visible the cycle after.
// No backpressure: rdy low freezes tables and statistics while lookups keep answering from the held state.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int         IDX_BITS = BpIdxBus,
    parameter int         TAG_BITS = BpTagBus,
    parameter logic [1:0] CNT_INIT = CNT_WNT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] if_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i,
    input  logic        upd_mispred_i,
    output logic [31:0] stat_branches_o,
    output logic [31:0] stat_mispred_o
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_LO  = IDX_BITS + 2;
    localparam int TAG_HI  = IDX_BITS + TAG_BITS + 1;

    // BTB storage (indexed by PC) and direction counters (indexed by PC or PC^history).
    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          cnt_q    [ENTRIES];

    logic [IDX_BITS-1:0] if_idx;
    logic [IDX_BITS-1:0] if_cidx;
    logic [TAG_BITS-1:0] if_tag;
    logic                if_hit;

    logic [IDX_BITS-1:0] upd_idx;
    logic [IDX_BITS-1:0] upd_cidx;
    logic [TAG_BITS-1:0] upd_tag;
    logic                upd_hit;
    logic                upd_acc;
    logic [1:0]          cnt_nxt;

    logic [31:0]         stat_branches_q;
    logic [31:0]         stat_mispred_q;

    // Byte-offset and above-tag PC bits play no part in indexing or matching.
    logic                upd_pc_unused;
    assign upd_pc_unused = ^{upd_pc_i[31:TAG_HI+1], upd_pc_i[1:0]};

    assign if_idx  = if_pc_i[IDX_BITS+1:2];
    assign if_tag  = if_pc_i[TAG_HI:TAG_LO];
    assign upd_idx = upd_pc_i[IDX_BITS+1:2];
    assign upd_tag = upd_pc_i[TAG_HI:TAG_LO];

    assign upd_acc = rdy && upd_valid_i;

`ifdef BP_GSHARE_EN
    // Global history of resolved directions; trained only by committed outcomes, so a flush needs no repair.
    logic [IDX_BITS-1:0] ghr_q;

    assign if_cidx  = if_idx ^ ghr_q;
    // Uses the pre-shift history, matching the value the lookup saw for this branch.
    assign upd_cidx = upd_idx ^ ghr_q;

    // Shift each accepted outcome into the history.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (upd_acc) begin
            ghr_q <= {ghr_q[IDX_BITS-2:0], upd_taken_i};
        end
    end
`else
    assign if_cidx  = if_idx;
    assign upd_cidx = upd_idx;
`endif

    // Lookup reads the registered tables, so a same-cycle update is not yet visible.
    always_comb begin
        if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken_o  = if_hit && cnt_q[if_cidx][1];
        pred_target_o = pred_taken_o ? target_q[if_idx] : pc_next_seq(if_pc_i);
    end

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    bp_sat_counter u_sat_counter (
        .cnt     (cnt_q[upd_cidx]),
        .taken   (upd_taken_i),
        .cnt_nxt (cnt_nxt)
    );

    // Valid bits and counters: taken outcomes allocate/refresh, not-taken only trains an existing entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_INIT;
            end
        end else if (upd_acc) begin
            if (upd_taken_i) begin
                valid_q[upd_idx] <= 1'b1;
                // A replaced entry restarts weakly taken rather than inheriting the old branch's confidence.
                cnt_q[upd_cidx]  <= upd_hit ? cnt_nxt : CNT_WT;
            end else if (upd_hit) begin
                cnt_q[upd_cidx]  <= cnt_nxt;
            end
        end
    end

    // Tag and target payload; left uninitialised at reset since valid gates every use.
    always_ff @(posedge clk) begin
        if (!rst && upd_acc && upd_taken_i) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target_i;
        end
    end

    // Saturating statistics; a mispredict flag without a valid update is not a resolved branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else if (upd_acc) begin
            if (stat_branches_q != 32'hFFFF_FFFF) begin
                stat_branches_q <= stat_branches_q + 32'd1;
            end
            if (upd_mispred_i && (stat_mispred_q != 32'hFFFF_FFFF)) begin
                stat_mispred_q <= stat_mispred_q + 32'd1;
            end
        end
    end

    assign stat_branches_o = stat_branches_q;
    assign stat_mispred_o  = stat_mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed test of branch_predictor: lookup, training, aliasing, collision, rdy hold, statistics and reset.
// Inputs change 1 time unit after the rising edge; outputs are compared 1 time unit after that.
// No handshake on the design; every step is a fixed number of cycles.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] if_pc_i;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        upd_mispred_i;
    logic [31:0] stat_branches_o;
    logic [31:0] stat_mispred_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .if_pc_i         (if_pc_i),
        .pred_taken_o    (pred_taken_o),
        .pred_target_o   (pred_target_o),
        .upd_valid_i     (upd_valid_i),
        .upd_pc_i        (upd_pc_i),
        .upd_taken_i     (upd_taken_i),
        .upd_target_i    (upd_target_i),
        .upd_mispred_i   (upd_mispred_i),
        .stat_branches_o (stat_branches_o),
        .stat_mispred_o  (stat_mispred_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic query(input logic [31:0] pc);
        if_pc_i = pc;
        #1;
    endtask

    // One accepted-or-not update cycle; inputs return to idle afterwards.
    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt, input logic mis);
        upd_valid_i   = 1'b1;
        upd_pc_i      = pc;
        upd_taken_i   = taken;
        upd_target_i  = tgt;
        upd_mispred_i = mis;
        tick();
        upd_valid_i   = 1'b0;
        upd_mispred_i = 1'b0;
    endtask

    task automatic pred(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        query(pc);
        chk({tag, "_taken"}, {31'd0, pred_taken_o}, {31'd0, tk});
        chk({tag, "_target"}, pred_target_o, tgt);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; if_pc_i = '0;
        upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0;
        upd_target_i = '0; upd_mispred_i = 1'b0;
        #1;
        tick(); tick();
        rst = 1'b0;

        // Reset state.
        pred("rst_q1000", 32'h1000, 1'b0, 32'h1004);
        chk("rst_branches", stat_branches_o, 32'd0);
        chk("rst_mispred", stat_mispred_o, 32'd0);

        // Collision: first taken update while the same PC is looked up.
        query(32'h1000);
        upd_valid_i = 1'b1; upd_pc_i = 32'h1000; upd_taken_i = 1'b1;
        upd_target_i = 32'h0F00; upd_mispred_i = 1'b1;
        #1;
        chk("coll_same_cycle", {31'd0, pred_taken_o}, 32'd0);
        chk("coll_same_target", pred_target_o, 32'h1004);
        tick();
        upd_valid_i = 1'b0; upd_mispred_i = 1'b0;
        pred("alloc", 32'h1000, 1'b1, 32'h0F00);       // counter 10
        chk("alloc_branches", stat_branches_o, 32'd1);

        // Three more taken: 11, 11, 11.
        for (int i = 0; i < 3; i++) begin
            upd(32'h1000, 1'b1, 32'h0F00, 1'b0);
            pred("strong", 32'h1000, 1'b1, 32'h0F00);
        end
        // Not-taken: 10 (taken), 01 (not), 00 (not).
        upd(32'h1000, 1'b0, 32'h0, 1'b0);
        pred("nt1", 32'h1000, 1'b1, 32'h0F00);
        upd(32'h1000, 1'b0, 32'h0, 1'b1);
        pred("nt2", 32'h1000, 1'b0, 32'h1004);
        upd(32'h1000, 1'b0, 32'h0, 1'b0);
        pred("nt3", 32'h1000, 1'b0, 32'h1004);
        chk("train_branches", stat_branches_o, 32'd7);
        chk("train_mispred", stat_mispred_o, 32'd2);

        // Aliasing: 0x1200 shares the index of 0x1000 with a different tag.
        upd(32'h1000, 1'b1, 32'h0F00, 1'b0);            // counter 00 -> 01
        pred("alias_miss", 32'h1200, 1'b0, 32'h1204);
        upd(32'h1200, 1'b1, 32'h2000, 1'b0);            // replace, counter 10
        pred("alias_new", 32'h1200, 1'b1, 32'h2000);
        pred("alias_old", 32'h1000, 1'b0, 32'h1004);

        // rdy low: update is ignored, statistics hold.
        rdy = 1'b0;
        upd(32'h1000, 1'b1, 32'h0F00, 1'b1);
        rdy = 1'b1;
        pred("rdy0_old", 32'h1000, 1'b0, 32'h1004);
        pred("rdy0_cur", 32'h1200, 1'b1, 32'h2000);
        chk("rdy0_branches", stat_branches_o, 32'd9);
        chk("rdy0_mispred", stat_mispred_o, 32'd2);

        // Not-taken on a tag miss must not touch the resident entry's counter.
        upd(32'h1000, 1'b0, 32'h0, 1'b0);
        pred("nt_miss_keep", 32'h1200, 1'b1, 32'h2000);
        chk("nt_miss_branches", stat_branches_o, 32'd10);

        // Clear, then five updates with two mispredicts plus a stray mispredict flag.
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2_branches", stat_branches_o, 32'd0);
        for (int i = 0; i < 5; i++) begin
            upd(32'h3000 + 32'(i * 4), 1'b1, 32'h5000 + 32'(i * 16), (i == 1 || i == 3));
        end
        upd_mispred_i = 1'b1; tick(); upd_mispred_i = 1'b0;
        chk("stat_branches5", stat_branches_o, 32'd5);
        chk("stat_mispred2", stat_mispred_o, 32'd2);
        pred("seq_hit", 32'h3000, 1'b1, 32'h5000);
        pred("seq_hit4", 32'h3010, 1'b1, 32'h5040);

        // Reset wins over a simultaneous update.
        rst = 1'b1;
        upd(32'h3008, 1'b1, 32'h7777, 1'b1);
        rst = 1'b0;
        chk("rst3_branches", stat_branches_o, 32'd0);
        chk("rst3_mispred", stat_mispred_o, 32'd0);
        pred("rst3_q3000", 32'h3000, 1'b0, 32'h3004);
        pred("rst3_q3008", 32'h3008, 1'b0, 32'h300C);
        pred("rst3_q1200", 32'h1200, 1'b0, 32'h1204);

        // Fall-through wraps at the top of the address space.
        pred("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side producer of the prediction bit and target offset that travel down the pipeline with each instruction. Consumer of the resolved outcome reported back by EX.
- Each cycle the fetch stage presents a PC. The block answers combinationally with taken/not-taken plus a predicted target, using a direct-mapped BTB and 2-bit saturating counters.
- EX returns the actual outcome of each resolved branch or jump, and the tables are trained from it.

Parameters:
- IDX_BITS, 7, log2 of the table entry count (128 entries).
- TAG_BITS, 8, width of the partial PC tag held per BTB entry.
- CNT_INIT, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- clk input 1: clock.
- rst input 1: reset, synchronous, active-high.
- rdy input 1: global ready. While low, no state changes.
- if_pc_i input 32: PC being fetched this cycle.
- pred_taken_o output 1: prediction for if_pc_i; goes down the pipeline as jmp_status.
- pred_target_o output 32: predicted next PC. Equals if_pc_i+4 when pred_taken_o=0.
- upd_valid_i input 1: EX has resolved a branch or jump this cycle.
- upd_pc_i input 32: PC of the resolved instruction.
- upd_taken_i input 1: actual direction.
- upd_target_i input 32: actual taken target.
- upd_mispred_i input 1: EX flagged a wrong prediction; same signal that drives the pipeline flush.
- stat_branches_o output 32: count of resolved updates.
- stat_mispred_o output 32: count of mispredictions.

Behaviour:
- Address fields:
  - idx = pc[IDX_BITS+1:2].
  - tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2].
  - pc[1:0] is ignored.
- Storage per entry: valid (1 bit), tag (TAG_BITS), target (32 bits), counter (2 bits).
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx]==tag(if_pc_i).
  - pred_taken_o = hit && cnt[idx][1].
  - pred_target_o = pred_taken_o ? target[idx] : if_pc_i+4, with 32-bit wrap.
- Update, applied on the posedge when rdy && upd_valid_i:
  - Counter: upd_taken_i=1 saturates upward at 2'b11; 0 saturates downward at 2'b00.
  - If upd_taken_i=1: write valid=1, tag and target. If the tag differs, the entry is replaced and the counter is set to 2'b10 instead of incremented.
  - If upd_taken_i=0 and the tag misses: no allocation and no counter change.
- Read/write collision (same idx in the same cycle): lookup returns the pre-update contents; the new value is visible from the next cycle.
- Statistics:
  - stat_branches_o increments on each accepted update.
  - stat_mispred_o increments when upd_valid_i && upd_mispred_i.
  - Both saturate at 32'hFFFFFFFF with no wrap.
  - upd_mispred_i without upd_valid_i is ignored.
- rdy=0: tables and statistics hold. Lookup outputs stay combinationally valid.
- Reset, including in the middle of operation:
  - All valid bits cleared, counters set to CNT_INIT, statistics set to 0.
  - Tag and target contents need not be cleared.
  - Output state after reset: pred_taken_o=0, pred_target_o=if_pc_i+4.
  - rst has priority over rdy and over any update in the same cycle.

Optional Feature:
- BP_GSHARE_EN defined:
  - Adds an IDX_BITS-wide global history register, reset to 0.
  - Counter index becomes idx XOR ghr. BTB index is unchanged.
  - On each accepted update, ghr <= {ghr[IDX_BITS-2:0], upd_taken_i}.
  - History is non-speculative, so no repair is needed on flush.
  - The update's counter index uses the ghr value from before the shift.
- BP_GSHARE_EN undefined: no ghr; counters indexed by idx only.

Decomposition:
- Shared defines header gains:
  - BpIdxBus and BpTagBus width macros.
  - Counter encodings: CNT_SNT=2'b00, CNT_WNT=2'b01, CNT_WT=2'b10, CNT_ST=2'b11.
  - The PC+4 increment constant.
- One natural sub-module: bp_sat_counter, the combinational 2-bit saturating next-state function.
- Storage arrays stay in branch_predictor.

Test Plan:
- Reset, then query pc=0x1000 -> pred_taken_o=0, pred_target_o=0x1004, both statistics 0.
- Update pc=0x1000 taken, target 0x0F00; next cycle query 0x1000 -> taken=1, target=0x0F00 (counter 2'b10).
- Same branch: 3 further taken updates, then 3 not-taken -> counter goes 11, 11, 11, then 10, 01, 00. Prediction is taken until the second not-taken update and not-taken after it.
- Aliasing: update 0x1000 taken, then query 0x1200 (same idx, different tag) -> taken=0, target=0x1204. Update 0x1200 taken -> entry replaced; query 0x1000 now misses.
- Collision: query 0x1000 in the same cycle as its first taken update -> returns not-taken that cycle and taken the next cycle. With rdy=0 during an update -> no change and statistics held.
- 5 updates with 2 carrying upd_mispred_i=1, plus 1 cycle of upd_mispred_i without upd_valid_i -> stat_branches_o=5, stat_mispred_o=2. Assert rst mid-sequence -> both return to 0 and all entries miss.
